// File: rtl/freq_sweep_pkg.sv
// Shared types and defaults for the stepped-frequency sweep generator.
package freq_sweep_pkg;

  localparam int PHASE_WIDTH_DEF = 24;
  localparam int DWELL_WIDTH_DEF = 16;
  localparam int STEP_WIDTH_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A zero-length dwell or step count behaves as one.
  function automatic logic [31:0] clamp_min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/freq_sweep_phase_gen_dwell_counter.sv
// Beat counter for one dwell: load sets the terminal value and zeroes the count,
// clear zeroes the count, advance counts up and wraps to 0 after the terminal value.
module sweep_dwell_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] last_val,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] cnt,
  output logic             terminal
);

  logic [WIDTH-1:0] last_reg;

  assign terminal = (cnt == last_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      last_reg <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt      <= '0;
      last_reg <= last_val;
    end else if (advance) begin
      cnt <= terminal ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/freq_sweep_phase_gen.sv
// Stepped-frequency sweep generator emitting AXI-Stream phase increments.
// Optional SWEEP_CONT_EN macro adds the cont port for continuously repeating sweeps.
module freq_sweep_phase_gen
  import freq_sweep_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF,
  parameter int STEP_WIDTH  = STEP_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] start_inc,
  input  logic [PHASE_WIDTH-1:0] step_inc,
  input  logic [STEP_WIDTH-1:0]  num_steps,
  input  logic [DWELL_WIDTH-1:0] dwell_len,
`ifdef SWEEP_CONT_EN
  input  logic                   cont,
`endif
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic                   phase_tvalid,
  output logic                   phase_tlast,
  input  logic                   phase_tready,
  output logic                   busy,
  output logic [STEP_WIDTH-1:0]  step_idx,
  output logic                   done
);

  state_t state, state_next;

  logic [PHASE_WIDTH-1:0] start_inc_sh, step_inc_sh;
  logic [STEP_WIDTH-1:0]  steps_last;
  logic [DWELL_WIDTH-1:0] dwell_last;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic                   dwell_term;
  logic                   cont_sh;
  logic                   accept, last_step, launch, step_end;

  assign dwell_last = DWELL_WIDTH'(clamp_min1(32'(dwell_len)) - 32'd1);

  assign phase_tvalid = (state == ST_RUN);
  assign busy         = (state == ST_RUN);
  assign done         = (state == ST_DONE);
  assign accept       = phase_tvalid & phase_tready;
  assign last_step    = (step_idx == steps_last);
  assign phase_tlast  = last_step & dwell_term & phase_tvalid;
  assign launch       = (state == ST_IDLE) & start & ~abort;
  assign step_end     = accept & dwell_term & ~abort;

  sweep_dwell_counter #(.WIDTH(DWELL_WIDTH)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .last_val (dwell_last),
    .clear    (abort),
    .advance  (accept),
    .cnt      (dwell_cnt),
    .terminal (dwell_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_next = ST_RUN;
        ST_RUN:  if (accept && dwell_term && last_step && !cont_sh) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Shadow config and the phase accumulator; config only moves on launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_inc_sh <= '0;
      step_inc_sh  <= '0;
      steps_last   <= '0;
      phase_inc    <= '0;
      step_idx     <= '0;
    end else if (launch) begin
      start_inc_sh <= start_inc;
      step_inc_sh  <= step_inc;
      steps_last   <= STEP_WIDTH'(clamp_min1(32'(num_steps)) - 32'd1);
      phase_inc    <= start_inc;
      step_idx     <= '0;
    end else if (step_end) begin
      if (!last_step) begin
        phase_inc <= phase_inc + step_inc_sh;
        step_idx  <= step_idx + STEP_WIDTH'(1);
      end else if (cont_sh) begin
        phase_inc <= start_inc_sh;
        step_idx  <= '0;
      end
    end
  end

`ifdef SWEEP_CONT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cont_sh <= 1'b0;
    else if (launch) cont_sh <= cont;
  end
`else
  assign cont_sh = 1'b0;
`endif

endmodule

// File: tb/tb_freq_sweep_phase_gen.sv
// Scoreboard bench for freq_sweep_phase_gen; builds with or without SWEEP_CONT_EN.
module tb_freq_sweep_phase_gen;

  localparam int PW = 24;
  localparam int DW = 16;
  localparam int SW = 10;

  logic          clk = 1'b0;
  logic          reset, start, abort, phase_tready;
  logic [PW-1:0] start_inc, step_inc;
  logic [SW-1:0] num_steps;
  logic [DW-1:0] dwell_len;
  logic          cont;
  logic [PW-1:0] phase_inc;
  logic          phase_tvalid, phase_tlast, busy, done;
  logic [SW-1:0] step_idx;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [PW-1:0] data;
    logic          last;
    logic [SW-1:0] step;
  } beat_t;

  beat_t sb[$];

  always #5 clk = ~clk;

  freq_sweep_phase_gen dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .start_inc    (start_inc),
    .step_inc     (step_inc),
    .num_steps    (num_steps),
    .dwell_len    (dwell_len),
`ifdef SWEEP_CONT_EN
    .cont         (cont),
`endif
    .phase_inc    (phase_inc),
    .phase_tvalid (phase_tvalid),
    .phase_tlast  (phase_tlast),
    .phase_tready (phase_tready),
    .busy         (busy),
    .step_idx     (step_idx),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep(input logic [PW-1:0] si, input logic [PW-1:0] st,
                            input int n, input int d, input int reps);
    logic [PW-1:0] v;
    int ne, de;
    ne = (n == 0) ? 1 : n;
    de = (d == 0) ? 1 : d;
    for (int r = 0; r < reps; r++) begin
      v = si;
      for (int s = 0; s < ne; s++) begin
        for (int k = 0; k < de; k++) begin
          sb.push_back('{data: v, last: (s == ne - 1) && (k == de - 1), step: SW'(s)});
        end
        v = v + st;
      end
    end
  endtask

  task automatic launch(input logic [PW-1:0] si, input logic [PW-1:0] st,
                        input int n, input int d, input logic c);
    @(negedge clk);
    start_inc    = si;
    step_inc     = st;
    num_steps    = SW'(n);
    dwell_len    = DW'(d);
    cont         = c;
    phase_tready = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble config to show it is shadowed.
    start_inc = 24'hABCDEF;
    step_inc  = 24'h111111;
    num_steps = SW'(7);
    dwell_len = DW'(5);
    check("launch_tvalid", 32'(phase_tvalid), 32'd1);
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_step", 32'(step_idx), 32'd0);
  endtask

  task automatic drain(input bit toggle, input int budget);
    int cyc;
    bit stalled;
    logic [PW-1:0] held;
    logic held_last;
    beat_t e;
    cyc = 0;
    stalled = 0;
    held = '0;
    held_last = 1'b0;
    while (sb.size() > 0 && cyc < budget) begin
      if (stalled) begin
        check("stall_valid", 32'(phase_tvalid), 32'd1);
        check("stall_data", 32'(phase_inc), 32'(held));
        check("stall_last", 32'(phase_tlast), 32'(held_last));
      end
      phase_tready = toggle ? ~cyc[0] : 1'b1;
      if (phase_tvalid && phase_tready) begin
        e = sb.pop_front();
        check("beat_data", 32'(phase_inc), 32'(e.data));
        check("beat_last", 32'(phase_tlast), 32'(e.last));
        check("beat_step", 32'(step_idx), 32'(e.step));
        stalled = 0;
      end else if (phase_tvalid) begin
        stalled   = 1;
        held      = phase_inc;
        held_last = phase_tlast;
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic expect_done();
    check("done_pulse", 32'(done), 32'd1);
    check("done_tvalid", 32'(phase_tvalid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    phase_tready = 1'b0;
    start_inc = '0;
    step_inc = '0;
    num_steps = '0;
    dwell_len = '0;
    cont = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_phase", 32'(phase_inc), 32'd0);
    check("rst_tvalid", 32'(phase_tvalid), 32'd0);
    check("rst_tlast", 32'(phase_tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step", 32'(step_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Basic sweep, tready high.
    push_sweep(24'h001000, 24'h000800, 3, 2, 1);
    launch(24'h001000, 24'h000800, 3, 2, 1'b0);
    drain(1'b0, 50);
    expect_done();

    // Same sweep with tready toggling.
    push_sweep(24'h001000, 24'h000800, 3, 2, 1);
    launch(24'h001000, 24'h000800, 3, 2, 1'b0);
    drain(1'b1, 100);
    expect_done();

    // Wrap upward, then a negative step.
    push_sweep(24'hFFF000, 24'h002000, 2, 1, 1);
    launch(24'hFFF000, 24'h002000, 2, 1, 1'b0);
    drain(1'b0, 50);
    expect_done();
    push_sweep(24'h003000, 24'hFFF000, 3, 1, 1);
    launch(24'h003000, 24'hFFF000, 3, 1, 1'b0);
    drain(1'b1, 50);
    expect_done();

    // Zero counts behave as one: a single tlast beat.
    push_sweep(24'h012345, 24'h000100, 0, 0, 1);
    launch(24'h012345, 24'h000100, 0, 0, 1'b0);
    check("single_tlast", 32'(phase_tlast), 32'd1);
    drain(1'b0, 20);
    expect_done();

    // Abort during step 1, with start in the same cycle.
    launch(24'h001000, 24'h000800, 3, 2, 1'b0);
    phase_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_pre_step", 32'(step_idx), 32'd1);
    check("abort_pre_data", 32'(phase_inc), 32'h001800);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_tvalid", 32'(phase_tvalid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check("abort_done2", 32'(done), 32'd0);
    check("abort_busy2", 32'(busy), 32'd0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("idle_abort_start", 32'(busy), 32'd0);

    // Asynchronous reset mid-sweep.
    launch(24'h001000, 24'h000800, 3, 2, 1'b0);
    phase_tready = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_phase", 32'(phase_inc), 32'd0);
    check("arst_tvalid", 32'(phase_tvalid), 32'd0);
    check("arst_tlast", 32'(phase_tlast), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_step", 32'(step_idx), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    phase_tready = 1'b0;
    @(negedge clk);

`ifdef SWEEP_CONT_EN
    // Continuous mode: A,B,A,B with tlast on every B and no done.
    push_sweep(24'h000100, 24'h000100, 2, 1, 2);
    launch(24'h000100, 24'h000100, 2, 1, 1'b1);
    drain(1'b0, 50);
    check("cont_done", 32'(done), 32'd0);
    check("cont_busy", 32'(busy), 32'd1);
    check("cont_reload", 32'(phase_inc), 32'h000100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("cont_abort", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
